// File: rtl/icache_loader_pkg.sv
// Shared definitions for the I-cache program loader, the core and the I-cache.
package icache_loader_pkg;

   localparam int ICACHE_ADDR_W = 10;
   localparam int INSTR_W       = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_RUN   = 2'd3
   } loader_state_e;

endpackage

// File: rtl/icache_loader_if.sv
// Instruction-word stream into the loader and the I-cache write port out of it.
interface icache_loader_if
   import icache_loader_pkg::*;
#(
   parameter int ADDR_W = ICACHE_ADDR_W,
   parameter int DATA_W = INSTR_W
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              ic_we;
   logic [ADDR_W-1:0] ic_waddr;
   logic [DATA_W-1:0] ic_wdata;

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, ic_we, ic_waddr, ic_wdata
   );

   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, ic_we, ic_waddr, ic_wdata
   );
endinterface

// File: rtl/icache_loader.sv
// Fills the I-cache from a valid/ready word stream starting at address 0,
// then holds start high to release the core.
//
// state | meaning
// IDLE  | after reset, waiting for load
// LOAD  | accepting words, one write per transfer
// FLUSH | final write lands, no transfers
// RUN   | start=1, counters frozen until next load
module icache_loader
   import icache_loader_pkg::*;
#(
   parameter int ADDR_W = ICACHE_ADDR_W,
   parameter int DATA_W = INSTR_W,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              load,
   icache_loader_if.slave    bus,
   output logic              start,
   output logic              busy,
   output logic [ADDR_W:0]   word_count,
   output logic [DATA_W-1:0] checksum,
   output logic              overflow
);

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] LOAD  = ST_LOAD;
   localparam logic [1:0] FLUSH = ST_FLUSH;
   localparam logic [1:0] RUN   = ST_RUN;

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

   logic [1:0] state;
   logic       xfer;

   assign bus.in_ready = (state == LOAD);
   assign busy         = (state == LOAD) || (state == FLUSH);
   assign start        = (state == RUN);
   assign xfer         = bus.in_valid & bus.in_ready;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state        <= IDLE;
         bus.ic_we    <= 1'b0;
         bus.ic_waddr <= '0;
         bus.ic_wdata <= '0;
         word_count   <= '0;
         checksum     <= '0;
         overflow     <= 1'b0;
      end else begin
         bus.ic_we <= 1'b0;
         case (state)
            IDLE, RUN: begin
               if (load) begin
                  word_count <= '0;
                  checksum   <= '0;
                  overflow   <= 1'b0;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               if (xfer) begin
                  bus.ic_we    <= 1'b1;
                  bus.ic_waddr <= word_count[ADDR_W-1:0];
                  bus.ic_wdata <= bus.in_data;
                  word_count   <= word_count + 1'b1;
                  checksum     <= checksum + bus.in_data;
                  // in_last on the DEPTH-th word is a clean exact fill, not an overflow
                  if (bus.in_last) begin
                     state <= FLUSH;
                  end else if (word_count == LAST_CNT) begin
                     overflow <= 1'b1;
                     state    <= FLUSH;
                  end
               end
            end
            FLUSH:   state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_loader.sv
// Directed bench for icache_loader with a write scoreboard and a reference model.
module tb_icache_loader;

   localparam int AW = 10;
   localparam int DW = 32;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic          Clk = 1'b0;
   logic          Rst_n;
   logic          load;
   logic          start;
   logic          busy;
   logic [AW:0]   word_count;
   logic [DW-1:0] checksum;
   logic          overflow;

   icache_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   icache_loader dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .load       (load),
      .bus        (bus),
      .start      (start),
      .busy       (busy),
      .word_count (word_count),
      .checksum   (checksum),
      .overflow   (overflow)
   );

   always #5 Clk = ~Clk;

   int            total = 0;
   int            bad   = 0;
   wr_t           exp_q[$];
   logic [AW:0]   exp_cnt;
   logic [DW-1:0] exp_sum;
   logic          exp_ovf;
   logic [DW-1:0] basic_sum;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every write seen on the cache port must match the oldest pending transfer.
   always @(negedge Clk) begin
      if (Rst_n === 1'b1 && bus.ic_we === 1'b1) begin
         total++;
         assert (exp_q.size() != 0)
         else begin
            bad++;
            $error("FAIL unexpected_write observed addr=%0h expected no write", bus.ic_waddr);
         end
         if (exp_q.size() != 0) begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", DW'(bus.ic_waddr), DW'(e.a));
            chk("wr_data", bus.ic_wdata, e.d);
         end
      end
   end

   task automatic do_load();
      @(negedge Clk);
      load    = 1'b1;
      exp_cnt = '0;
      exp_sum = '0;
      exp_ovf = 1'b0;
      @(negedge Clk);
      load = 1'b0;
      chk("load_start_low", DW'(start), 0);
      chk("load_in_ready", DW'(bus.in_ready), 1);
      chk("load_cnt_clr", DW'(word_count), 0);
      chk("load_sum_clr", checksum, 0);
      chk("load_ovf_clr", DW'(overflow), 0);
   endtask

   // Presents one word from a falling edge; returns just after the accepting rising edge.
   task automatic send(input logic [DW-1:0] d, input logic last);
      int n;
      wr_t e;
      @(negedge Clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 10) begin
         @(negedge Clk);
         n++;
      end
      if (n == 10) chk("send_ready_timeout", DW'(bus.in_ready), 1);
      if (bus.in_ready === 1'b1) begin
         e.a = exp_cnt[AW-1:0];
         e.d = d;
         exp_q.push_back(e);
         exp_cnt = exp_cnt + 1'b1;
         exp_sum = exp_sum + d;
         if (!last && exp_cnt == (AW+1)'(1 << AW)) exp_ovf = 1'b1;
      end
      @(posedge Clk);
   endtask

   task automatic finish_check(input string tag);
      @(negedge Clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk({tag, "_flush_start"}, DW'(start), 0);
      chk({tag, "_flush_busy"}, DW'(busy), 1);
      chk({tag, "_flush_ready"}, DW'(bus.in_ready), 0);
      @(negedge Clk);
      chk({tag, "_start"}, DW'(start), 1);
      chk({tag, "_busy"}, DW'(busy), 0);
      chk({tag, "_count"}, DW'(word_count), DW'(exp_cnt));
      chk({tag, "_checksum"}, checksum, exp_sum);
      chk({tag, "_overflow"}, DW'(overflow), DW'(exp_ovf));
      chk({tag, "_pending"}, exp_q.size(), 0);
   endtask

   initial begin
      logic [DW-1:0] prog [3];
      prog[0] = 32'h2001_0005;
      prog[1] = 32'h2002_0003;
      prog[2] = 32'h0022_1820;

      Rst_n = 1'b0;
      load  = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      exp_cnt = '0;
      exp_sum = '0;
      exp_ovf = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_start", DW'(start), 0);
      chk("rst_we", DW'(bus.ic_we), 0);
      chk("rst_ready", DW'(bus.in_ready), 0);
      chk("rst_count", DW'(word_count), 0);
      chk("rst_checksum", checksum, 0);
      chk("rst_overflow", DW'(overflow), 0);

      // in_valid in IDLE is ignored
      Rst_n = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hdead_beef;
      repeat (3) @(negedge Clk);
      chk("idle_count", DW'(word_count), 0);
      chk("idle_ready", DW'(bus.in_ready), 0);
      bus.in_valid = 1'b0;

      // basic back-to-back load
      do_load();
      for (int i = 0; i < 3; i++) send(prog[i], i == 2);
      finish_check("basic");
      basic_sum = exp_sum;

      // gaps between words; a load pulse inside LOAD is ignored
      do_load();
      for (int i = 0; i < 3; i++) begin
         send(prog[i], i == 2);
         if (i < 2) begin
            @(negedge Clk);
            bus.in_valid = 1'b0;
            load = (i == 0);
            @(negedge Clk);
            load = 1'b0;
            @(negedge Clk);
         end
      end
      finish_check("gaps");
      chk("gaps_same_checksum", checksum, basic_sum);
      chk("gaps_same_count", DW'(word_count), 3);

      // overflow: DEPTH words without in_last
      do_load();
      for (int i = 0; i < 1024; i++) send(32'h1, 1'b0);
      finish_check("ovf");
      chk("ovf_model", DW'(exp_ovf), 1);
      chk("ovf_last_addr", DW'(bus.ic_waddr), 1023);
      chk("ovf_checksum_abs", checksum, 32'h400);

      // exact fill: in_last on the DEPTH-th word
      do_load();
      for (int i = 0; i < 1024; i++) send(32'h1, i == 1023);
      finish_check("exact");
      chk("exact_count_abs", DW'(word_count), 1024);

      // reload from RUN, new program from address 0
      do_load();
      send(32'h1234_5678, 1'b0);
      send(32'h8765_4321, 1'b1);
      finish_check("reload");

      // reset mid-load
      do_load();
      send(32'haaaa_0001, 1'b0);
      send(32'haaaa_0002, 1'b0);
      #1 Rst_n = 1'b0;
      #1;
      chk("mrst_we", DW'(bus.ic_we), 0);
      chk("mrst_waddr", DW'(bus.ic_waddr), 0);
      chk("mrst_wdata", bus.ic_wdata, 0);
      chk("mrst_ready", DW'(bus.in_ready), 0);
      chk("mrst_busy", DW'(busy), 0);
      chk("mrst_count", DW'(word_count), 0);
      chk("mrst_checksum", checksum, 0);
      exp_q.delete();
      @(negedge Clk);
      Rst_n = 1'b1;
      bus.in_valid = 1'b1;
      repeat (3) @(negedge Clk);
      chk("mrst_idle_ready", DW'(bus.in_ready), 0);
      chk("mrst_idle_count", DW'(word_count), 0);
      bus.in_valid = 1'b0;
      do_load();
      send(32'h0bad_cafe, 1'b1);
      finish_check("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
